// File: rtl/data_receiver.sv
// Receive side of the transmission/serial_clk/serial_data link: synchronizes the three lines,
// shifts in one DATA_WIDTH-bit word per frame MSB first, and flags short/long frames.
// Optional frame timeout is enabled by defining DATA_RECEIVER_TIMEOUT_EN.
module data_receiver #(
   parameter int DATA_WIDTH     = 64,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          transmission,
   input  logic                          serial_clk,
   input  logic                          serial_data,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          data_valid,
   output logic                          frame_error,
   output logic                          busy,
   output logic [$clog2(DATA_WIDTH+1):0] bit_count
);

   localparam int BCW = $clog2(DATA_WIDTH+1) + 1;
   localparam logic [BCW-1:0] BC_FULL = BCW'(DATA_WIDTH);
   localparam logic [BCW-1:0] BC_OVF  = BCW'(DATA_WIDTH + 1);

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("data_receiver: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

   logic [SYNC_STAGES-1:0] tx_sync_q, tx_sync_d;
   logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d;
   logic [SYNC_STAGES-1:0] dt_sync_q, dt_sync_d;
   logic                   tx_dly_q, tx_dly_d;
   logic                   ck_dly_q, ck_dly_d;
   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [DATA_WIDTH-1:0]  out_q, out_d;
   logic [BCW-1:0]         bcnt_q, bcnt_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic                   pend_q, pend_d;

`ifdef DATA_RECEIVER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   logic sync_tx, sync_ck, sync_dt;
   logic tx_rise, tx_fall, sclk_rise;

   assign sync_tx   = tx_sync_q[SYNC_STAGES-1];
   assign sync_ck   = ck_sync_q[SYNC_STAGES-1];
   assign sync_dt   = dt_sync_q[SYNC_STAGES-1];
   assign tx_rise   = sync_tx & ~tx_dly_q;
   assign tx_fall   = ~sync_tx & tx_dly_q;
   assign sclk_rise = sync_ck & ~ck_dly_q;

   always_comb begin
      tx_sync_d = {tx_sync_q[SYNC_STAGES-2:0], transmission};
      ck_sync_d = {ck_sync_q[SYNC_STAGES-2:0], serial_clk};
      dt_sync_d = {dt_sync_q[SYNC_STAGES-2:0], serial_data};
      tx_dly_d  = sync_tx;
      ck_dly_d  = sync_ck;
      state_d   = state_q;
      shift_d   = shift_q;
      out_d     = out_q;
      bcnt_d    = bcnt_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      pend_d    = pend_q;
`ifdef DATA_RECEIVER_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            // pend_q carries a frame start that arrived while CHECK was busy
            if (tx_rise || pend_q) begin
               state_d = RECEIVE;
               shift_d = '0;
               bcnt_d  = '0;
               pend_d  = 1'b0;
`ifdef DATA_RECEIVER_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         RECEIVE: begin
            if (sclk_rise) begin
               if (bcnt_q < BC_FULL) shift_d = {shift_q[DATA_WIDTH-2:0], sync_dt};
               if (bcnt_q != BC_OVF) bcnt_d = bcnt_q + BCW'(1);
            end
            if (tx_fall) state_d = CHECK;
`ifdef DATA_RECEIVER_TIMEOUT_EN
            tmo_d = sclk_rise ? '0 : tmo_q + TW'(1);
            // a stalled serial clock abandons the frame; its eventual tx_fall lands in IDLE
            if (!sclk_rise && !tx_fall && tmo_q == TMO_MAX) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
`endif
         end
         CHECK: begin
            state_d = IDLE;
            if (bcnt_q == BC_FULL) begin
               out_d   = shift_q;
               valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
            if (tx_rise) pend_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RECEIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sync_q <= '0;
         ck_sync_q <= '0;
         dt_sync_q <= '0;
         tx_dly_q  <= 1'b0;
         ck_dly_q  <= 1'b0;
         state_q   <= IDLE;
         shift_q   <= '0;
         out_q     <= '0;
         bcnt_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         pend_q    <= 1'b0;
`ifdef DATA_RECEIVER_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         tx_sync_q <= tx_sync_d;
         ck_sync_q <= ck_sync_d;
         dt_sync_q <= dt_sync_d;
         tx_dly_q  <= tx_dly_d;
         ck_dly_q  <= ck_dly_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         out_q     <= out_d;
         bcnt_q    <= bcnt_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         pend_q    <= pend_d;
`ifdef DATA_RECEIVER_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign out_data    = out_q;
   assign data_valid  = valid_q;
   assign frame_error = err_q;
   assign busy        = busy_q;
   assign bit_count   = bcnt_q;

endmodule

// File: tb/tb_data_receiver.sv
// Randomized bench for data_receiver: drives serial frames and compares every result pulse
// against a frame-level reference model (word, bit count, latency, held output).
module tb_data_receiver;

   localparam int DW = 64;
   localparam int SS = 2;
`ifdef DATA_RECEIVER_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 65535;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic transmission = 1'b0;
   logic serial_clk = 1'b0;
   logic serial_data = 1'b0;
   logic [DW-1:0] out_data;
   logic data_valid, frame_error, busy;
   logic [$clog2(DW+1):0] bit_count;

   longint cyc = 0;
   int nvec = 0;
   int nerr = 0;
   logic [63:0] ref_out = '0;

   typedef struct {
      bit          good;
      logic [63:0] out;
      int          nbits;
      longint      fall_cyc;
   } exp_t;
   exp_t exp_q[$];

   data_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .transmission(transmission), .serial_clk(serial_clk),
      .serial_data(serial_data), .out_data(out_data), .data_valid(data_valid),
      .frame_error(frame_error), .busy(busy), .bit_count(bit_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: a frame is good only with exactly DW bits; otherwise output is held
   task automatic expect_frame(input logic [63:0] w, input int n, input longint fc);
      exp_t e;
      e.good = (n == DW);
      if (e.good) ref_out = w;
      e.out      = ref_out;
      e.nbits    = (n > DW + 1) ? DW + 1 : n;
      e.fall_cyc = fc;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && (data_valid || frame_error)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {62'd0, data_valid, frame_error}, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("data_valid", 64'(data_valid), 64'(e.good));
            chk("frame_error", 64'(frame_error), 64'(!e.good));
            chk("out_data", 64'(out_data), e.out);
            chk("bit_count", 64'(bit_count), 64'(e.nbits));
            if (e.fall_cyc >= 0) chk("latency", 64'(cyc - e.fall_cyc), 64'(SS + 2));
         end
      end
   end

   task automatic clock_bits(input logic [63:0] w, input int n, input int h, output longint last_rise);
      last_rise = cyc;
      for (int i = 0; i < n; i++) begin
         #1 serial_data = (i < 64) ? w[63-i] : 1'($urandom);
         repeat (h) @(posedge clk);
         #1 serial_clk = 1'b1;
         last_rise = cyc;
         repeat (h) @(posedge clk);
         #1 serial_clk = 1'b0;
         if (i == n / 2 && n >= 8) chk("busy_in_frame", 64'(busy), 64'd1);
      end
   endtask

   task automatic send_frame(input logic [63:0] w, input int n, input int gap);
      int h;
      longint lr;
      h = $urandom_range(4, 6);
      @(posedge clk);
      #1 transmission = 1'b1;
      repeat (2) @(posedge clk);
      clock_bits(w, n, h, lr);
      repeat (h) @(posedge clk);
      #1 transmission = 1'b0;
      expect_frame(w, n, cyc);
      repeat (gap) @(posedge clk);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1 chk("busy_idle", 64'(busy), 64'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_data_valid", 64'(data_valid), 64'd0);
      chk("rst_frame_error", 64'(frame_error), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_bit_count", 64'(bit_count), 64'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w;
      longint lr;
      longint d;
      int n;
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs();
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      send_frame(64'h0123456789ABCDEF, 64, 4);
      drain();
      send_frame({$urandom, $urandom}, 63, 4);
      drain();
      send_frame({$urandom, $urandom}, 65, 4);
      drain();
      send_frame(64'hAAAAAAAAAAAAAAAA, 64, 1);
      send_frame(64'h5555555555555555, 64, 4);
      drain();
      send_frame({$urandom, $urandom}, 0, 4);
      drain();

      for (int f = 0; f < 10; f++) begin
         case ($urandom_range(0, 4))
            0, 1:    n = DW;
            2:       n = DW - 1;
            3:       n = DW + $urandom_range(1, 3);
            default: n = $urandom_range(0, DW);
         endcase
         send_frame({$urandom, $urandom}, n, $urandom_range(1, 6));
      end
      drain();

      // async reset in the middle of a frame, then a clean frame
      send_frame(64'hC3C3_1234_5678_9ABC, 64, 4);
      drain();
      @(posedge clk);
      #1 transmission = 1'b1;
      repeat (2) @(posedge clk);
      clock_bits({$urandom, $urandom}, 30, 5, lr);
      rst_n = 1'b0;
      #1 chk_reset_outputs();
      transmission = 1'b0;
      serial_clk = 1'b0;
      serial_data = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs();
      rst_n = 1'b1;
      ref_out = '0;
      repeat (3) @(posedge clk);
      send_frame(64'hFFFF0000FFFF0000, 64, 4);
      drain();

`ifdef DATA_RECEIVER_TIMEOUT_EN
      @(posedge clk);
      #1 transmission = 1'b1;
      repeat (2) @(posedge clk);
      w = {$urandom, $urandom};
      clock_bits(w, 10, 5, lr);
      expect_frame(w, 10, -1);
      begin
         int k;
         k = 0;
         while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
         end
      end
      chk("tmo_pulse", 64'(exp_q.size()), 64'd0);
      d = cyc - lr;
      chk("tmo_window", 64'(d >= TMO && d <= TMO + SS + 8), 64'd1);
      #1 chk("tmo_busy", 64'(busy), 64'd0);
      transmission = 1'b0;
      repeat (20) @(posedge clk);
      send_frame(64'h0F1E2D3C4B5A6978, 64, 4);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/data_receiver.md
Name: data_receiver

Overview:
Receive end of the three-wire serial link (transmission / clock / data) driven by data_transmitter. Samples the external frame, clock and data lines in the local clk domain, shifts in one DATA_WIDTH-bit word per frame, and presents it with a one-cycle valid strobe. Frames that are too short or too long are flagged as errors. Sits at a board input next to the generators and counter blocks and feeds the captured word to downstream logic.

Parameters:
DATA_WIDTH, 64, bits per frame and width of out_data.
SYNC_STAGES, 2, flip-flop stages on each serial input; legal values are 2 or more.
TIMEOUT_CYCLES, 65535, clk cycles allowed between serial clock rising edges inside a frame. Used only with the optional feature.

Ports:
clk  input  1  system clock; every flop is in this domain.
rst_n  input  1  asynchronous, active-low reset.
transmission  input  1  frame enable from the transmitter; high for the whole frame. Asynchronous to clk.
serial_clk  input  1  serial bit clock from the transmitter. Asynchronous to clk.
serial_data  input  1  serial data line. Asynchronous to clk.
out_data  output  DATA_WIDTH  last correctly received word.
data_valid  output  1  one-cycle pulse when out_data is updated.
frame_error  output  1  one-cycle pulse when a frame is bad.
busy  output  1  high while a frame is being received.
bit_count  output  $clog2(DATA_WIDTH+1)+1  bits captured so far in the current frame.

Behaviour:
- Reset:
  - rst_n low clears every flop at once: synchronizers, shift register, counter and state.
  - Reset values: out_data=0, data_valid=0, frame_error=0, busy=0, bit_count=0, state=IDLE.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops. One extra flop on synchronized serial_clk gives edge detection.
  - sclk_rise = sync_clk & ~sclk_d. tx_rise and tx_fall are derived the same way from synchronized transmission.
  - The receiver samples data on the rising edge of serial_clk. Bits arrive MSB first.
  - Inputs are only sampled on edges. The transmitter guarantees at least 4 clk cycles per serial_clk half-period and data stable around the rising edge.
- FSM, 3 states: IDLE, RECEIVE, CHECK.
  - IDLE: busy=0. On tx_rise, clear the shift register and bit_count, then go to RECEIVE. A sclk_rise in IDLE is ignored.
  - RECEIVE: busy=1. On each sclk_rise, shift_reg <= {shift_reg[DATA_WIDTH-2:0], sync_data}.
    - bit_count increments and saturates at DATA_WIDTH+1, which marks overflow. Bits beyond DATA_WIDTH are not shifted in.
    - On tx_fall, go to CHECK.
    - If sclk_rise and tx_fall happen in the same cycle, the bit is captured first, then the state moves to CHECK.
  - CHECK: lasts exactly one cycle, then returns to IDLE.
    - If bit_count==DATA_WIDTH: out_data <= shift_reg and data_valid=1 for that cycle.
    - Otherwise: frame_error=1 and out_data is held.
    - busy=0 in CHECK.
- Latency: data_valid is asserted SYNC_STAGES+2 clk cycles after the transmission pin falls.
- out_data holds its value until the next good frame.
- A tx_rise during CHECK is not lost. The next frame starts from IDLE one cycle later; the synchronized level is still high, so the FSM also accepts a latched tx_rise.
- A zero-bit frame (transmission pulse with no serial clock) gives frame_error.
- data_valid and frame_error are never high in the same cycle.

Optional Feature:
Macro DATA_RECEIVER_TIMEOUT_EN.
- Defined:
  - A counter runs in RECEIVE. It clears on entry to RECEIVE and on every sclk_rise, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE and pulses frame_error. out_data is unchanged.
  - A later tx_fall from that dead frame is ignored.
  - The next tx_rise starts a new frame. If transmission is still high after the timeout, the receiver waits for it to go low, then high again.
- Not defined: no counter and no timeout logic. RECEIVE lasts until tx_fall.

Test Plan:
- Good frame, DATA_WIDTH=64: send 64 bits of 0x0123456789ABCDEF MSB first → out_data=0x0123456789ABCDEF; one data_valid pulse SYNC_STAGES+2 cycles after transmission falls; bit_count=64; frame_error stays 0.
- Short frame: 63 clocks, then transmission falls → frame_error pulses once; data_valid=0; out_data keeps the previous value.
- Long frame: 65 clocks → bit_count saturates at 65; frame_error pulses; out_data is unchanged.
- Back-to-back frames 0xAAAAAAAAAAAAAAAA then 0x5555555555555555, with 2 idle clk cycles between them → two data_valid pulses, with out_data equal to each word in turn.
- Reset mid-frame: drop rst_n after 30 bits, release it, then send a full 64-bit frame of 0xFFFF0000FFFF0000 → all outputs are 0 during reset; the next frame is received correctly.
- DATA_RECEIVER_TIMEOUT_EN with TIMEOUT_CYCLES=100: stop serial_clk after 10 bits with transmission held high → frame_error at cycle 100 after the last edge; busy=0; a later transmission fall causes no further pulse.
